// File: rtl/theta_reconstruct_sequencer.sv
// ---------------------------------------------------------------------------
// theta_reconstruct_sequencer
//
// Rebuilds an N_DIM-element Cartesian vector w from N_DIM-1 hyperspherical
// angles and a magnitude. It does this by driving one shared, external,
// gain-compensated CORDIC rotation core, one angle per operation. Angles are
// consumed from the highest slot down to slot 0, so extraction followed by
// this block is a round trip (w -> theta,r -> w).
//
// Each operation rotates (r_reg, 0) by theta[k]:
//   k >= 1 : w[k+1] <= x, r_reg <= y   (y carries the remaining magnitude)
//   k == 0 : w[0]   <= x, w[1]  <= y
//
// Ports
//   clk, nreset     clock (rising edge), async active-low reset
//   start           1-cycle request, only sampled while idle
//   theta_in_flat   N_DIM-1 angles, slot k at [(k+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH]
//   r_in            magnitude
//   cordic_*        handshake with the rotation core; en is held until op_vld,
//                   nrst is dropped for a cycle after every result (core flush)
//   w_out_flat      result vector, element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//   busy            high from the accept cycle until done rises
//   done            1-cycle pulse, w_out_flat valid from this cycle
// ---------------------------------------------------------------------------
module theta_reconstruct_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int N_DIM       = 7
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             start,
  input  logic [(N_DIM-1)*ANGLE_WIDTH-1:0] theta_in_flat,
  input  logic [DATA_WIDTH-1:0]            r_in,
  input  logic [DATA_WIDTH-1:0]            cordic_xout,
  input  logic [DATA_WIDTH-1:0]            cordic_yout,
  input  logic                             cordic_op_vld,
  output logic                             cordic_nrst,
  output logic                             cordic_en,
  output logic [DATA_WIDTH-1:0]            cordic_xin,
  output logic [DATA_WIDTH-1:0]            cordic_yin,
  output logic [ANGLE_WIDTH-1:0]           cordic_zin,
  output logic [N_DIM*DATA_WIDTH-1:0]      w_out_flat,
  output logic                             busy,
  output logic                             done
);

  localparam int NA = N_DIM - 1;
  localparam int KW = $clog2(N_DIM);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                              state_q;
  logic [KW-1:0]                       k_q;
  logic [NA-1:0][ANGLE_WIDTH-1:0]      theta_q;
  logic [DATA_WIDTH-1:0]               r_q;
  logic [N_DIM-1:0][DATA_WIDTH-1:0]    w_q;
  logic                                nrst_q, en_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0]               xin_q;
  logic [ANGLE_WIDTH-1:0]              zin_q;

  logic [ANGLE_WIDTH-1:0]              zin_d;
  logic [N_DIM-1:0][DATA_WIDTH-1:0]    w_d;

  // Angle for the current step.
  always_comb begin
    zin_d = '0;
    for (int i = 0; i < NA; i++)
      if (k_q == KW'(i)) zin_d = theta_q[i];
  end

  // Intermediate write for k >= 1: x result lands in w[k+1].
  always_comb begin
    w_d = w_q;
    for (int i = 1; i < N_DIM; i++)
      if (k_q == KW'(i - 1)) w_d[i] = cordic_xout;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      theta_q <= '0;
      r_q     <= '0;
      w_q     <= '0;
      nrst_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xin_q   <= '0;
      zin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            theta_q <= theta_in_flat;
            r_q     <= r_in;
            k_q     <= KW'(NA - 1);
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // op_vld is deliberately not looked at here.
          nrst_q  <= 1'b1;
          en_q    <= 1'b1;
          xin_q   <= r_q;
          zin_q   <= zin_d;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cordic_op_vld) begin
            // Flush the core; it stays flushed at least through the next
            // S_ISSUE cycle.
            nrst_q <= 1'b0;
            en_q   <= 1'b0;
            if (k_q == '0) begin
              w_q[0]  <= cordic_xout;
              w_q[1]  <= cordic_yout;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              w_q     <= w_d;
              r_q     <= cordic_yout;
              k_q     <= k_q - KW'(1);
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cordic_nrst = nrst_q;
  assign cordic_en   = en_q;
  assign cordic_xin  = xin_q;
  assign cordic_yin  = '0;
  assign cordic_zin  = zin_q;
  assign w_out_flat  = w_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_theta_reconstruct_sequencer.sv
// Bench for theta_reconstruct_sequencer: three instances (N_DIM = 3, 7, 2),
// each paired with a behavioural gain-free rotation core with L = 18.
// Angle units: full scale of the signed z word is +/-pi.
module tb_theta_reconstruct_sequencer;
  localparam int  DW = 16;
  localparam int  AW = 16;
  localparam int  L  = 18;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0]    start_v = '0;
  logic [2:0]    spur    = '0;
  logic [31:0]   th0 = '0;
  logic [95:0]   th1 = '0;
  logic [15:0]   th2 = '0;
  logic [DW-1:0] r_s [3];
  logic          c_nrst [3];
  logic          c_en   [3];
  logic          c_vld  [3];
  logic [DW-1:0] c_xin  [3];
  logic [DW-1:0] c_yin  [3];
  logic [DW-1:0] c_xout [3];
  logic [DW-1:0] c_yout [3];
  logic [AW-1:0] c_zin  [3];
  logic [47:0]   w0;
  logic [111:0]  w1;
  logic [31:0]   w2;
  logic [2:0]    busy_v, done_v;
  real           refw [7];

  theta_reconstruct_sequencer #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(3)) dut3 (
    .clk(clk), .nreset(nreset), .start(start_v[0]), .theta_in_flat(th0), .r_in(r_s[0]),
    .cordic_xout(c_xout[0]), .cordic_yout(c_yout[0]), .cordic_op_vld(c_vld[0]),
    .cordic_nrst(c_nrst[0]), .cordic_en(c_en[0]), .cordic_xin(c_xin[0]), .cordic_yin(c_yin[0]),
    .cordic_zin(c_zin[0]), .w_out_flat(w0), .busy(busy_v[0]), .done(done_v[0]));

  theta_reconstruct_sequencer #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(7)) dut7 (
    .clk(clk), .nreset(nreset), .start(start_v[1]), .theta_in_flat(th1), .r_in(r_s[1]),
    .cordic_xout(c_xout[1]), .cordic_yout(c_yout[1]), .cordic_op_vld(c_vld[1]),
    .cordic_nrst(c_nrst[1]), .cordic_en(c_en[1]), .cordic_xin(c_xin[1]), .cordic_yin(c_yin[1]),
    .cordic_zin(c_zin[1]), .w_out_flat(w1), .busy(busy_v[1]), .done(done_v[1]));

  theta_reconstruct_sequencer #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .N_DIM(2)) dut2 (
    .clk(clk), .nreset(nreset), .start(start_v[2]), .theta_in_flat(th2), .r_in(r_s[2]),
    .cordic_xout(c_xout[2]), .cordic_yout(c_yout[2]), .cordic_op_vld(c_vld[2]),
    .cordic_nrst(c_nrst[2]), .cordic_en(c_en[2]), .cordic_xin(c_xin[2]), .cordic_yin(c_yin[2]),
    .cordic_zin(c_zin[2]), .w_out_flat(w2), .busy(busy_v[2]), .done(done_v[2]));

  function automatic real ang(input logic [AW-1:0] z);
    return $itor($signed(z)) * PI / 32768.0;
  endfunction

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  function automatic logic [DW-1:0] to_w(input real v);
    int i;
    i = rnd(v);
    return i[DW-1:0];
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int el(input int g, input int i);
    logic signed [DW-1:0] s;
    case (g)
      0:       s = w0[i*DW +: DW];
      1:       s = w1[i*DW +: DW];
      default: s = w2[i*DW +: DW];
    endcase
    return int'(s);
  endfunction

  // Behavioural rotation core: result L cycles after en rises, 1-cycle valid,
  // flushed whenever nrst or en is low. spur[] injects a stray valid with
  // recognisable garbage data.
  for (genvar g = 0; g < 3; g++) begin : g_core
    int   cnt = 0;
    int   en_rises = 0;
    int   ops = 0;
    logic fired = 1'b0, vld = 1'b0, en_prev = 1'b0;
    logic [DW-1:0] xo = '0, yo = '0;
    always @(posedge clk) begin
      en_prev <= c_en[g];
      if (c_en[g] && !en_prev) en_rises <= en_rises + 1;
      if (!c_nrst[g] || !c_en[g]) begin
        cnt <= 0; fired <= 1'b0; vld <= 1'b0;
      end else if (vld) begin
        vld <= 1'b0; fired <= 1'b1;
      end else if (!fired) begin
        if (cnt == L - 1) begin
          vld <= 1'b1;
          ops <= ops + 1;
          xo  <= to_w($itor($signed(c_xin[g])) * $cos(ang(c_zin[g]))
                    - $itor($signed(c_yin[g])) * $sin(ang(c_zin[g])));
          yo  <= to_w($itor($signed(c_xin[g])) * $sin(ang(c_zin[g]))
                    + $itor($signed(c_yin[g])) * $cos(ang(c_zin[g])));
        end
        cnt <= cnt + 1;
      end
    end
    assign c_vld[g]  = vld | spur[g];
    assign c_xout[g] = spur[g] ? 16'h7abc : xo;
    assign c_yout[g] = spur[g] ? 16'h5123 : yo;
  end

  // Closed-form hyperspherical -> Cartesian for n elements.
  task automatic ref_fwd(input int n, input real r, input logic [95:0] thf);
    real p;
    int  lo;
    for (int i = 0; i < 7; i++) refw[i] = 0.0;
    for (int i = 0; i < n; i++) begin
      lo = (i < 1) ? 1 : i;
      p  = r;
      for (int j = lo; j <= n - 2; j++) p = p * $sin(ang(thf[j*AW +: AW]));
      if (i == 1) refw[i] = p * $sin(ang(thf[AW-1:0]));
      else        refw[i] = p * $cos(ang(thf[(lo-1)*AW +: AW]));
    end
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk) start_v[g] = 1'b1;
    @(negedge clk) start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done_v[g]) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({busy_v[g], done_v[g], c_nrst[g], c_en[g], c_xin[g], c_yin[g], c_zin[g]} !== '0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: busy=%b done=%b nrst=%b en=%b xin=%h zin=%h, required all 0",
                 g, busy_v[g], done_v[g], c_nrst[g], c_en[g], c_xin[g], c_zin[g]);
      end
    end
    checks++;
    if ({w0, w1, w2} !== '0) begin
      errors++; $display("FAIL reset_w: w3=%h w7=%h w2=%h, required 0", w0, w1, w2);
    end
    @(negedge clk) nreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_angles;
    bit seen;
    int ops0;
    ops0 = g_core[0].ops;
    r_s[0] = 16'h4000; th0 = '0;
    pulse_start(0);
    checks++;
    if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL zero_busy_run: busy=%b required 1", busy_v[0]); end
    wait_done(0, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL zero_done: no done within budget"); end
    checks++;
    if (el(0,2) !== 16384 || el(0,1) !== 0 || el(0,0) !== 0) begin
      errors++; $display("FAIL zero_w: w2=%0d w1=%0d w0=%0d, required 16384 0 0", el(0,2), el(0,1), el(0,0));
    end
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done: busy=%b required 0", busy_v[0]); end
    @(negedge clk);
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      errors++; $display("FAIL zero_after: done=%b busy=%b required 0 0", done_v[0], busy_v[0]);
    end
    checks++;
    if (g_core[0].ops - ops0 !== 2) begin
      errors++; $display("FAIL zero_ops: ops=%0d required 2", g_core[0].ops - ops0);
    end
  endtask

  task automatic test_quarter_turn;
    bit seen;
    int ops0, en0;
    ops0 = g_core[0].ops; en0 = g_core[0].en_rises;
    r_s[0] = 16'h4000; th0 = {16'd16384, 16'd0};
    pulse_start(0);
    wait_done(0, seen);
    checks++;
    if (!seen || iabs(el(0,2)) > 2 || iabs(el(0,1)) > 2 || iabs(el(0,0) - 16384) > 2) begin
      errors++; $display("FAIL quarter_w: done=%b w2=%0d w1=%0d w0=%0d, required 0 0 16384 (+/-2)",
                         seen, el(0,2), el(0,1), el(0,0));
    end
    checks++;
    if (g_core[0].ops - ops0 !== 2 || g_core[0].en_rises - en0 !== 2) begin
      errors++; $display("FAIL quarter_ops: vld=%0d en=%0d required 2 2",
                         g_core[0].ops - ops0, g_core[0].en_rises - en0);
    end
  endtask

  task automatic test_ndim2;
    bit seen;
    int ops0;
    ops0 = g_core[2].ops;
    r_s[2] = 16'h3000; th2 = 16'd8192;
    pulse_start(2);
    wait_done(2, seen);
    checks++;
    if (!seen || iabs(el(2,0) - rnd(12288.0 * $cos(PI/4.0))) > 2
              || iabs(el(2,1) - rnd(12288.0 * $sin(PI/4.0))) > 2) begin
      errors++; $display("FAIL ndim2_w: done=%b w0=%0d w1=%0d, required 8689 8689 (+/-2)", seen, el(2,0), el(2,1));
    end
    checks++;
    if (g_core[2].ops - ops0 !== 1) begin
      errors++; $display("FAIL ndim2_ops: ops=%0d required 1", g_core[2].ops - ops0);
    end
  endtask

  task automatic test_round_trip;
    int  wv [7];
    real rr, a;
    int  z, rq;
    bit  seen;
    for (int v = 0; v < 200; v++) begin
      for (int i = 0; i < 7; i++) wv[i] = int'($urandom_range(0, 4000)) - 2000;
      // Extraction: theta0 from (w0,w1), then theta_k from (w[k+1], r_{k-1}).
      a  = $atan2($itor(wv[1]), $itor(wv[0]));
      rr = $sqrt($itor(wv[0]*wv[0] + wv[1]*wv[1]));
      z  = rnd(a * 32768.0 / PI); th1[AW-1:0] = z[AW-1:0];
      for (int k = 1; k < 6; k++) begin
        a  = $atan2(rr, $itor(wv[k+1]));
        rr = $sqrt($itor(wv[k+1]*wv[k+1]) + rr*rr);
        z  = rnd(a * 32768.0 / PI); th1[k*AW +: AW] = z[AW-1:0];
      end
      rq = rnd(rr); r_s[1] = rq[DW-1:0];
      pulse_start(1);
      wait_done(1, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL rt_done[%0d]: no done within budget", v); end
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (iabs(el(1,i) - wv[i]) > 4) begin
          errors++; $display("FAIL rt_w[%0d][%0d]: got %0d required %0d (+/-4)", v, i, el(1,i), wv[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy;
    bit  seen;
    int  ops0, dones, c, r0;
    logic [31:0] tacc;
    ops0 = g_core[0].ops;
    r0 = int'($urandom_range(16'h1000, 16'h3000));
    tacc = $urandom;
    r_s[0] = r0[DW-1:0]; th0 = tacc;
    ref_fwd(3, $itor(r0), {64'd0, tacc});
    @(negedge clk) start_v[0] = 1'b1;
    seen = 1'b0; dones = 0;
    for (c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (done_v[0]) begin seen = 1'b1; dones++; end
      else begin th0 = $urandom; r_s[0] = 16'($urandom); end
    end
    // start stays high through the S_DONE cycle; it must be ignored there.
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL busy_start_in_done: busy=%b required 0", busy_v[0]); end
    start_v[0] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL busy_dones: dones=%0d required 1", dones); end
    checks++;
    if (g_core[0].ops - ops0 !== 2) begin
      errors++; $display("FAIL busy_ops: ops=%0d required 2", g_core[0].ops - ops0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (iabs(el(0,i) - rnd(refw[i])) > 4) begin
        errors++; $display("FAIL busy_w[%0d]: got %0d required %0d (+/-4)", i, el(0,i), rnd(refw[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen;
    r_s[0] = 16'h2000; th0 = '0;
    pulse_start(0);
    wait_done(0, seen);
    checks++;
    if (!seen || el(0,2) !== 8192) begin
      errors++; $display("FAIL b2b_first: done=%b w2=%0d required 8192", seen, el(0,2));
    end
    // The very next cycle after done is idle: start there must be accepted.
    @(negedge clk) begin start_v[0] = 1'b1; r_s[0] = 16'h1000; th0 = {16'd16384, 16'd0}; end
    @(negedge clk) start_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b required 1", busy_v[0]); end
    wait_done(0, seen);
    checks++;
    if (!seen || iabs(el(0,0) - 4096) > 2 || iabs(el(0,1)) > 2 || iabs(el(0,2)) > 2) begin
      errors++; $display("FAIL b2b_second: done=%b w0=%0d w1=%0d w2=%0d required 4096 0 0 (+/-2)",
                         seen, el(0,0), el(0,1), el(0,2));
    end
  endtask

  task automatic test_reset_mid;
    int  en0, c;
    bit  seen, bad_done;
    en0 = g_core[0].en_rises;
    r_s[0] = 16'h4000; th0 = {16'd0, 16'd8192};
    pulse_start(0);
    for (c = 0; c < 500 && (g_core[0].en_rises - en0) < 2; c++) @(negedge clk);
    checks++;
    if (c >= 500) begin errors++; $display("FAIL rmid_second_op: en rises=%0d required 2", g_core[0].en_rises - en0); end
    repeat (5) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_v[0], done_v[0], c_nrst[0], c_en[0], c_xin[0], c_zin[0], w0} !== '0) begin
      errors++; $display("FAIL rmid_outputs: busy=%b done=%b nrst=%b en=%b xin=%h zin=%h w=%h required all 0",
                         busy_v[0], done_v[0], c_nrst[0], c_en[0], c_xin[0], c_zin[0], w0);
    end
    bad_done = 1'b0;
    repeat (2) @(negedge clk) if (done_v[0]) bad_done = 1'b1;
    nreset = 1'b1;
    repeat (40) @(negedge clk) if (done_v[0] || busy_v[0]) bad_done = 1'b1;
    checks++;
    if (bad_done) begin errors++; $display("FAIL rmid_no_done: done/busy seen after reset, required none"); end
    r_s[0] = 16'h4000; th0 = '0;
    pulse_start(0);
    wait_done(0, seen);
    checks++;
    if (!seen || el(0,2) !== 16384 || el(0,1) !== 0 || el(0,0) !== 0) begin
      errors++; $display("FAIL rmid_restart: done=%b w2=%0d w1=%0d w0=%0d required 16384 0 0",
                         seen, el(0,2), el(0,1), el(0,0));
    end
  endtask

  task automatic test_spurious_vld;
    logic [47:0] wb;
    int ops0;
    bit seen;
    wb = w0;
    @(negedge clk) spur[0] = 1'b1;
    @(negedge clk) spur[0] = 1'b0;
    checks++;
    if (w0 !== wb || busy_v[0] !== 1'b0 || c_en[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++; $display("FAIL spur_idle: w=%h busy=%b en=%b done=%b required w=%h 0 0 0",
                         w0, busy_v[0], c_en[0], done_v[0], wb);
    end
    ops0 = g_core[0].ops;
    r_s[0] = 16'h1234; th0 = '0;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) begin start_v[0] = 1'b0; spur[0] = 1'b1; end
    @(negedge clk) spur[0] = 1'b0;
    checks++;
    if (w0 !== wb || c_en[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
      errors++; $display("FAIL spur_issue: w=%h en=%b busy=%b required w=%h 1 1", w0, c_en[0], busy_v[0], wb);
    end
    wait_done(0, seen);
    checks++;
    if (!seen || el(0,2) !== 16'h1234 || el(0,1) !== 0 || el(0,0) !== 0 || g_core[0].ops - ops0 !== 2) begin
      errors++; $display("FAIL spur_run: done=%b w2=%0d w1=%0d w0=%0d ops=%0d required 4660 0 0 2",
                         seen, el(0,2), el(0,1), el(0,0), g_core[0].ops - ops0);
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) r_s[g] = '0;
    test_reset();
    test_zero_angles();
    test_quarter_turn();
    test_ndim2();
    test_round_trip();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_spurious_vld();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
